// File: rtl/sreg_pipe_pkg.sv
// Shared helpers for the sreg_pipe register pipeline: count width and DEPTH legality.
package sreg_pipe_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 1) && (depth <= 64);
    endfunction

endpackage

// File: rtl/sreg_pipe_if.sv
// Valid/ready stream bus into and out of sreg_pipe, plus the occupancy count.
interface sreg_pipe_if #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 4
) ();
    import sreg_pipe_pkg::*;

    localparam int CW = clog2(DEPTH + 1);

    logic                        InValid;
    logic signed [DATAWIDTH-1:0] InData;
    logic                        InReady;
    logic                        OutValid;
    logic signed [DATAWIDTH-1:0] OutData;
    logic                        OutReady;
    logic [CW-1:0]               Count;

    modport master (
        output InValid, InData, OutReady,
        input  InReady, OutValid, OutData, Count
    );

    modport slave (
        input  InValid, InData, OutReady,
        output InReady, OutValid, OutData, Count
    );

endinterface

// File: rtl/sreg_pipe_stage.sv
// One pipeline stage: signed data register and valid bit with load enable.
// Flush clears only the valid bit; the data register keeps its contents.
module sreg_stage #(
    parameter int DATAWIDTH = 8
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Flush,
    input  logic                        Load,
    input  logic signed [DATAWIDTH-1:0] DIn,
    input  logic                        VIn,
    output logic signed [DATAWIDTH-1:0] DOut,
    output logic                        VOut
);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            DOut <= '0;
            VOut <= 1'b0;
        end else if (Flush) begin
            VOut <= 1'b0;
        end else if (Load) begin
            DOut <= DIn;
            VOut <= VIn;
        end
    end

endmodule

// File: rtl/sreg_pipe.sv
// Elastic DEPTH-stage register pipeline with bubble collapse, flush and occupancy count.
module sreg_pipe
    import sreg_pipe_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Flush,
    sreg_pipe_if.slave bus
);

    localparam int CW = clog2(DEPTH + 1);

    generate
        if (!depth_ok(DEPTH)) begin : g_bad_depth
            $error("sreg_pipe: DEPTH must be in 1..64");
        end
    endgenerate

    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0]            move;
    logic [DEPTH-1:0]            load;
    logic signed [DATAWIDTH-1:0] data [DEPTH];
    logic [CW-1:0]               count;
    logic                        in_ready;
    logic                        out_valid;
    logic                        in_fire;
    logic                        out_fire;

    always_comb begin
        move            = '0;
        move[DEPTH-1]   = bus.OutReady;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            move[k] = !valid[k+1] | move[k+1];
        end
    end

    // An empty stage always takes from upstream; otherwise its upstream neighbour,
    // which sees it as free, would advance and drop the beat it held.
    assign load      = move | ~valid;
    assign in_ready  = (!valid[0] | move[0]) & !Flush;
    assign out_valid = valid[DEPTH-1] & !Flush;
    assign in_fire   = bus.InValid & in_ready;
    assign out_fire  = out_valid & bus.OutReady;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic signed [DATAWIDTH-1:0] d_in;
            logic                        v_in;

            if (k == 0) begin : g_head
                assign d_in = bus.InData;
                assign v_in = bus.InValid;
            end else begin : g_body
                assign d_in = data[k-1];
                assign v_in = valid[k-1];
            end

            sreg_stage #(
                .DATAWIDTH (DATAWIDTH)
            ) u_stage (
                .Clk   (Clk),
                .Rst   (Rst),
                .Flush (Flush),
                .Load  (load[k]),
                .DIn   (d_in),
                .VIn   (v_in),
                .DOut  (data[k]),
                .VOut  (valid[k])
            );
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count <= '0;
        end else if (Flush) begin
            count <= '0;
        end else if (in_fire && !out_fire) begin
            count <= count + CW'(1);
        end else if (out_fire && !in_fire) begin
            count <= count - CW'(1);
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.OutData  = data[DEPTH-1];
    assign bus.Count    = count;

endmodule

// File: tb/tb_sreg_pipe.sv
// Directed bench for sreg_pipe with DATAWIDTH=8, DEPTH=3.
module tb_sreg_pipe;

    logic Clk;
    logic Rst;
    logic Flush;
    int   errors;
    int   checks;
    int   vals [4] = '{-5, 7, -128, 127};
    int   drain_d [3] = '{20, 30, 40};
    int   drain_c [3] = '{3, 2, 1};

    sreg_pipe_if #(.DATAWIDTH(8), .DEPTH(3)) bus ();

    sreg_pipe #(
        .DATAWIDTH (8),
        .DEPTH     (3)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Flush (Flush),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        Rst          = 1'b0;
        Flush        = 1'b0;
        bus.InValid  = 1'b0;
        bus.InData   = '0;
        bus.OutReady = 1'b0;

        // reset state
        #2;
        chk("rst_inready", bus.InReady, 1);
        chk("rst_outvalid", bus.OutValid, 0);
        chk("rst_count", bus.Count, 0);
        chk("rst_outdata", bus.OutData, 0);
        #1 Rst = 1'b1;
        step();

        // streaming
        bus.OutReady = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.InValid = (c < 4);
            bus.InData  = 8'(vals[c & 3]);
            #1;
            chk("stream_inready", bus.InReady, 1);
            chk("stream_outvalid", bus.OutValid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk("stream_outdata", bus.OutData, vals[c-3]);
            step();
        end
        chk("stream_count_end", bus.Count, 0);

        // full stall
        bus.OutReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.InValid = 1'b1;
            bus.InData  = 8'((c + 1) * 10);
            #1;
            chk("stall_accept", bus.InReady, 1);
            step();
        end
        bus.InData = 8'd40;
        #1;
        chk("stall_full_inready", bus.InReady, 0);
        chk("stall_full_count", bus.Count, 3);
        chk("stall_full_outdata", bus.OutData, 10);
        bus.OutReady = 1'b1;
        #1;
        chk("stall_release_inready", bus.InReady, 1);
        step();
        bus.InValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_drain_count", bus.Count, drain_c[c]);
            chk("stall_drain_outdata", bus.OutData, drain_d[c]);
            step();
        end
        chk("stall_empty_outvalid", bus.OutValid, 0);
        chk("stall_empty_count", bus.Count, 0);

        // bubble collapse
        bus.InValid = 1'b1;
        bus.InData  = 8'd1;
        step();
        bus.OutReady = 1'b0;
        bus.InData   = 8'd2;
        #1;
        chk("bubble_accept2", bus.InReady, 1);
        step();
        bus.InData = 8'd3;
        #1;
        chk("bubble_accept3", bus.InReady, 1);
        step();
        bus.InValid = 1'b0;
        #1;
        chk("bubble_count", bus.Count, 3);
        bus.OutReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bubble_order_valid", bus.OutValid, 1);
            chk("bubble_order_data", bus.OutData, c + 1);
            step();
        end
        chk("bubble_empty", bus.OutValid, 0);

        // flush
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b1;
        bus.InData   = 8'd50;
        step();
        bus.InData = 8'd60;
        step();
        bus.InValid = 1'b0;
        #1;
        chk("flush_pre_count", bus.Count, 2);
        step();
        chk("flush_pre_outvalid", bus.OutValid, 1);
        chk("flush_pre_outdata", bus.OutData, 50);
        Flush       = 1'b1;
        bus.InValid = 1'b1;
        bus.InData  = 8'd99;
        #1;
        chk("flush_inready", bus.InReady, 0);
        chk("flush_outvalid", bus.OutValid, 0);
        step();
        Flush        = 1'b0;
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        #1;
        chk("flush_count", bus.Count, 0);
        chk("flush_data_kept", bus.OutData, 50);
        for (int c = 0; c < 4; c++) begin
            chk("flush_no_output", bus.OutValid, 0);
            step();
        end

        // asynchronous reset mid-stream
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b1;
        bus.InData   = 8'd70;
        step();
        bus.InData = 8'd80;
        step();
        bus.InValid = 1'b0;
        step();
        chk("arst_pre_count", bus.Count, 2);
        chk("arst_pre_outdata", bus.OutData, 70);
        #1 Rst = 1'b0;
        #1;
        chk("arst_outvalid", bus.OutValid, 0);
        chk("arst_count", bus.Count, 0);
        chk("arst_outdata", bus.OutData, 0);
        chk("arst_inready", bus.InReady, 1);
        #1 Rst = 1'b1;
        step();

        // recovery after reset
        bus.OutReady = 1'b1;
        bus.InValid  = 1'b1;
        bus.InData   = -8'sd1;
        step();
        bus.InValid = 1'b0;
        #1;
        chk("recover_latency_early", bus.OutValid, 0);
        step();
        step();
        chk("recover_outvalid", bus.OutValid, 1);
        chk("recover_outdata", bus.OutData, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sreg_pipe.md
SREG_PIPE -- requirements
Module: SREG_PIPE

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8: width of the signed data path.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages; legal range 1..64.
REQ-003 SHALL have port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port Flush, input, 1: synchronous clear of all stage valids.
REQ-006 SHALL have port InValid, input, 1: upstream beat present.
REQ-007 SHALL have port InData, input, DATAWIDTH, signed: upstream beat.
REQ-008 SHALL have port InReady, output, 1: block accepts a beat this cycle.
REQ-009 SHALL have port OutValid, output, 1: last stage holds a beat.
REQ-010 SHALL have port OutData, output, DATAWIDTH, signed: last-stage data.
REQ-011 SHALL have port OutReady, input, 1: downstream accepts a beat.
REQ-012 SHALL have port Count, output, clog2(DEPTH+1): number of valid stages.

Function
REQ-013 SHALL implement DEPTH stages, each with a data register and a valid bit; stage 0 is nearest the input.
REQ-014 SHALL define move[DEPTH-1] = OutReady, and move[k] = !valid[k+1] | move[k+1] for k < DEPTH-1.
REQ-015 SHALL drive InReady = (!valid[0] | move[0]) & !Flush, combinationally with no register.
REQ-016 SHALL drive OutValid = valid[DEPTH-1] & !Flush, and OutData = data[DEPTH-1].
REQ-017 SHALL load stage k from stage k-1 (stage 0 from InData/InValid) when move[k] is true; otherwise stage k holds.
REQ-018 SHALL provide latency of exactly DEPTH cycles from input transfer to OutValid when OutReady is held high.
REQ-019 SHALL collapse bubbles: an empty stage accepts from upstream even while downstream is stalled.
REQ-020 SHALL sustain one transfer per cycle when InValid and OutReady are both continuously high.
REQ-021 SHALL preserve data bit-exactly, with no sign extension, truncation or reordering.
REQ-022 SHALL, when Flush=1, clear every valid bit at the edge, discard any input beat, leave data registers unchanged and set Count to 0 at the next edge.
REQ-023 SHALL update Count as a register: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither.
REQ-024 SHALL keep Count less than or equal to DEPTH; when full and OutReady=0, InReady SHALL be 0.
REQ-025 SHALL hold all stages stable when stalled, with OutData constant while OutValid=1 and OutReady=0.

Reset
REQ-026 SHALL, on Rst=0, asynchronously clear all valid bits, all data registers and Count to 0.
REQ-027 SHALL drive InReady=1 and OutValid=0 while in reset; reset release SHALL be synchronised externally.
REQ-028 SHALL, if reset is asserted mid-stream, lose in-flight beats; no partial transfer occurs.

Structure
REQ-029 SHALL keep the count-width function clog2 and the DEPTH legality check in the shared package; no typedefs are needed.
REQ-030 SHALL use one sub-module, SREG_STAGE (signed data register, valid bit and load enable), instantiated DEPTH times in a generate loop.

Verification
REQ-031 Bench SHALL use DATAWIDTH=8 and DEPTH=3 for all directed scenarios below.
REQ-032 Streaming: InValid=1 with InData -5,7,-128,127 on consecutive cycles and OutReady=1 -> OutData -5,7,-128,127 with OutValid first high 3 cycles after the first transfer, 1 per cycle.
REQ-033 Full stall: OutReady=0 while 4 beats are offered -> 3 accepted, Count=3, InReady=0; then OutReady=1 for one cycle -> 1 out, 4th accepted in the same cycle, Count stays 3.
REQ-034 Bubble collapse: 1 beat is injected, then OutReady=0 and 2 more beats are injected -> all accepted, Count=3, stage order preserved.
REQ-035 Flush: Count=2 with Flush=1 and InValid=1 -> InReady=0 and OutValid=0 in that cycle; next cycle Count=0 and the input beat is absent from the output.
REQ-036 Reset: Rst=0 asynchronously mid-stream with Count=2 -> OutValid=0, Count=0 and OutData=0 before the next Clk edge.
